// File: rtl/scroll_pkg.sv
// Shared types and constants for the background scroll sequencer.
// Also the source of the tilemap bound used by the renderer side.
package scroll_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        UPDATE  = 2'd1,
        DRAW    = 2'd2,
        RELEASE = 2'd3
    } scroll_state_e;

    // Largest legal left-edge tile so the screen never runs past the map.
    function automatic int max_offset(
        input int tilemap_length,
        input int screen_tiles
    );
        return tilemap_length - screen_tiles;
    endfunction

endpackage

// File: rtl/step_divider.sv
// Modulo-FRAMES_PER_STEP frame counter.
// Flags the frame on which a one-tile scroll step may be applied.
module step_divider #(
    parameter int FRAMES_PER_STEP = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic advance,
    output logic step
);

    localparam int CW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAMES_PER_STEP - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Advance the count once per update, wrapping after the last frame.
    always_comb begin
        count_d = count_q;
        if (advance) begin
            if (count_q == LAST) begin
                count_d = '0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Count register, cleared by synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign step = advance && (count_q == LAST);

endmodule

// File: rtl/scroll_controller.sv
// Per-frame scroll update followed by one background redraw handshake.
// x_offset only moves in UPDATE, so it is frozen for the whole redraw.
module scroll_controller #(
    parameter int TILEMAP_LENGTH  = 2000,
    parameter int SCREEN_TILES    = 20,
    parameter int FRAMES_PER_STEP = 4,
    parameter int OFFSET_W        = 11
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                frame_tick,
    input  logic                scroll_left,
    input  logic                scroll_right,
    input  logic                bg_done,
    output logic                bg_enable,
    output logic [OFFSET_W-1:0] x_offset,
    output logic                busy,
    output logic                overrun
);

    import scroll_pkg::*;

    localparam int MAX_OFFSET = max_offset(TILEMAP_LENGTH, SCREEN_TILES);
    localparam logic [OFFSET_W-1:0] MAX_OFF = OFFSET_W'(MAX_OFFSET);

    scroll_state_e       state_q;
    scroll_state_e       state_d;
    logic [OFFSET_W-1:0] x_offset_q;
    logic [OFFSET_W-1:0] x_offset_d;
    logic                bg_enable_q;
    logic                bg_enable_d;
    logic                busy_q;
    logic                busy_d;
    logic                overrun_q;
    logic                overrun_d;
    logic                step;
    logic                advance;

    assign advance = (state_q == UPDATE);

    step_divider #(
        .FRAMES_PER_STEP(FRAMES_PER_STEP)
    ) u_step_divider (
        .clock  (clock),
        .reset  (reset),
        .advance(advance),
        .step   (step)
    );

    // Next state, saturating offset update and registered output values.
    always_comb begin
        state_d    = state_q;
        x_offset_d = x_offset_q;
        unique case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                state_d = DRAW;
                if (step) begin
                    if (scroll_right && !scroll_left) begin
                        if (x_offset_q < MAX_OFF) begin
                            x_offset_d = x_offset_q + 1'b1;
                        end
                    end else if (scroll_left && !scroll_right) begin
                        if (x_offset_q != '0) begin
                            x_offset_d = x_offset_q - 1'b1;
                        end
                    end
                end
            end
            DRAW: begin
                if (bg_done) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (!bg_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        bg_enable_d = (state_d == DRAW);
        busy_d      = (state_d != IDLE);
        overrun_d   = frame_tick && (state_q != IDLE);
    end

    // State and output registers; reset also drops a pending enable.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            x_offset_q  <= '0;
            bg_enable_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_offset_q  <= x_offset_d;
            bg_enable_q <= bg_enable_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bg_enable = bg_enable_q;
    assign x_offset  = x_offset_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_scroll_controller.sv
// Scoreboard bench: frame stimulus pushes expected offsets,
// a monitor pops them when a redraw enable rises.
module tb_scroll_controller;

    localparam int MAXO = 1980;
    localparam int TMO  = 300;

    logic       clock = 1'b0;
    logic [1:0] rst   = 2'b11;
    logic [1:0] tick  = 2'b00;
    logic [1:0] scl   = 2'b00;
    logic [1:0] scr   = 2'b00;
    logic [1:0] done  = 2'b00;
    logic [1:0] en_o;
    logic [1:0] busy_o;
    logic [1:0] ov_o;
    logic [10:0] xo [2];

    int total = 0;
    int bad   = 0;
    int exp_q [$];
    int m_off [2] = '{0, 0};
    int m_cnt [2] = '{0, 0};
    int fps   [2] = '{4, 1};
    int done_at  [2] = '{5, 1};
    int rel_hold [2] = '{0, 0};
    int rcnt [2] = '{0, 0};
    int relc [2] = '{0, 0};
    int ov_cnt [2] = '{0, 0};
    logic [1:0] en_prev = 2'b00;
    logic [10:0] xo_prev [2] = '{11'd0, 11'd0};

    always #5 clock = ~clock;

    scroll_controller #(.FRAMES_PER_STEP(4)) u_a (
        .clock(clock), .reset(rst[0]), .frame_tick(tick[0]),
        .scroll_left(scl[0]), .scroll_right(scr[0]), .bg_done(done[0]),
        .bg_enable(en_o[0]), .x_offset(xo[0]), .busy(busy_o[0]),
        .overrun(ov_o[0])
    );

    scroll_controller #(.FRAMES_PER_STEP(1)) u_b (
        .clock(clock), .reset(rst[1]), .frame_tick(tick[1]),
        .scroll_left(scl[1]), .scroll_right(scr[1]), .bg_done(done[1]),
        .bg_enable(en_o[1]), .x_offset(xo[1]), .busy(busy_o[1]),
        .overrun(ov_o[1])
    );

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    // Renderer model: done after done_at enable cycles, held rel_hold extra.
    always @(negedge clock) begin
        for (int d = 0; d < 2; d++) begin
            if (en_o[d]) begin
                rcnt[d]++;
                relc[d] = 0;
                if (rcnt[d] >= done_at[d]) done[d] = 1'b1;
            end else begin
                rcnt[d] = 0;
                if (done[d]) begin
                    if (relc[d] >= rel_hold[d]) begin
                        done[d] = 1'b0;
                        relc[d] = 0;
                    end else begin
                        relc[d]++;
                    end
                end
            end
        end
    end

    // Monitor: offset at redraw start, offset frozen during redraw.
    always @(negedge clock) begin
        for (int d = 0; d < 2; d++) begin
            if (ov_o[d]) ov_cnt[d]++;
            if (en_o[d] && !en_prev[d]) begin
                if (exp_q.size() == 0) begin
                    check("draw_unexpected", 1, 0);
                end else begin
                    check("draw_offset", int'(xo[d]), exp_q.pop_front());
                end
            end else if (en_o[d] && en_prev[d]) begin
                check("draw_hold", int'(xo[d]), int'(xo_prev[d]));
            end else if (xo[d] != xo_prev[d] &&
                         !(xo[d] == 11'd0 && !busy_o[d])) begin
                check("offset_change", int'(xo[d]), int'(xo_prev[d]));
            end
            en_prev[d] = en_o[d];
            xo_prev[d] = xo[d];
        end
    end

    task automatic model_step(input int d, input bit l, input bit r);
        if (m_cnt[d] == fps[d] - 1) begin
            m_cnt[d] = 0;
            if (r && !l) begin
                if (m_off[d] < MAXO) m_off[d]++;
            end else if (l && !r) begin
                if (m_off[d] > 0) m_off[d]--;
            end
        end else begin
            m_cnt[d]++;
        end
    endtask

    task automatic start_frame(input int d, input bit l, input bit r);
        model_step(d, l, r);
        exp_q.push_back(m_off[d]);
        scl[d] = l;
        scr[d] = r;
        tick[d] = 1'b1;
        @(negedge clock);
        tick[d] = 1'b0;
    endtask

    task automatic frame(input int d, input bit l, input bit r,
                         output int en_n, output int busy_n);
        int k;
        start_frame(d, l, r);
        en_n = 0;
        busy_n = 0;
        k = 0;
        while (busy_o[d] && k < TMO) begin
            busy_n++;
            if (en_o[d]) en_n++;
            @(negedge clock);
            k++;
        end
        if (k >= TMO) check("frame_timeout", k, 0);
    endtask

    task automatic wait_en(input int d, input bit lvl, input string nm);
        int k;
        k = 0;
        while (en_o[d] != lvl && k < TMO) begin
            @(negedge clock);
            k++;
        end
        if (k >= TMO) check(nm, k, 0);
    endtask

    task automatic do_reset(input int d);
        rst[d] = 1'b1;
        @(negedge clock);
        @(negedge clock);
        rst[d] = 1'b0;
        m_off[d] = 0;
        m_cnt[d] = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int en_n;
        int busy_n;
        int base;
        int b;

        repeat (3) @(negedge clock);
        check("rst_enable", int'(en_o[0]), 0);
        check("rst_offset", int'(xo[0]), 0);
        check("rst_busy", int'(busy_o[0]), 0);
        check("rst_overrun", int'(ov_o[0]), 0);
        rst = 2'b00;
        @(negedge clock);

        frame(0, 1'b0, 1'b0, en_n, busy_n);
        check("t1_enable_cycles", en_n, 5);
        check("t1_busy_cycles", busy_n, 7);
        check("t1_offset", int'(xo[0]), 0);

        for (int i = 0; i < 8; i++) frame(0, 1'b0, 1'b1, en_n, busy_n);
        check("right8_offset", int'(xo[0]), 2);

        do_reset(0);
        check("reset_offset", int'(xo[0]), 0);
        for (int i = 0; i < 4; i++) frame(0, 1'b1, 1'b0, en_n, busy_n);
        check("left_at_zero", int'(xo[0]), 0);
        for (int i = 0; i < 4; i++) frame(0, 1'b0, 1'b1, en_n, busy_n);
        check("wrap_after_left", int'(xo[0]), 1);
        for (int i = 0; i < 4; i++) frame(0, 1'b1, 1'b1, en_n, busy_n);
        check("both_held", int'(xo[0]), 1);
        for (int i = 0; i < 4; i++) frame(0, 1'b0, 1'b1, en_n, busy_n);
        check("wrap_after_both", int'(xo[0]), 2);

        done_at[0] = 8;
        rel_hold[0] = 4;
        base = ov_cnt[0];
        start_frame(0, 1'b0, 1'b0);
        wait_en(0, 1'b1, "ovr_wait_draw");
        @(negedge clock);
        tick[0] = 1'b1;
        @(negedge clock);
        tick[0] = 1'b0;
        check("ovr_draw_pulse", int'(ov_o[0]), 1);
        @(negedge clock);
        check("ovr_draw_clear", int'(ov_o[0]), 0);
        wait_en(0, 1'b0, "ovr_wait_release");
        check("ovr_release_busy", int'(busy_o[0]), 1);
        tick[0] = 1'b1;
        @(negedge clock);
        tick[0] = 1'b0;
        check("ovr_rel_pulse", int'(ov_o[0]), 1);
        @(negedge clock);
        check("ovr_rel_clear", int'(ov_o[0]), 0);
        b = 0;
        while (busy_o[0] && b < TMO) begin
            @(negedge clock);
            b++;
        end
        b = 0;
        repeat (6) begin
            @(negedge clock);
            b += int'(busy_o[0]);
        end
        check("ovr_no_update", b, 0);
        check("ovr_pulses", ov_cnt[0] - base, 2);
        check("ovr_offset", int'(xo[0]), 2);
        check("ovr_queue", exp_q.size(), 0);

        done_at[0] = 10;
        rel_hold[0] = 0;
        start_frame(0, 1'b0, 1'b0);
        wait_en(0, 1'b1, "mid_wait_draw");
        @(negedge clock);
        @(negedge clock);
        rst[0] = 1'b1;
        @(negedge clock);
        rst[0] = 1'b0;
        m_off[0] = 0;
        m_cnt[0] = 0;
        check("mid_enable", int'(en_o[0]), 0);
        check("mid_offset", int'(xo[0]), 0);
        check("mid_busy", int'(busy_o[0]), 0);
        check("mid_overrun", int'(ov_o[0]), 0);
        @(negedge clock);
        done_at[0] = 5;
        frame(0, 1'b0, 1'b0, en_n, busy_n);
        check("post_enable_cycles", en_n, 5);
        check("post_busy_cycles", busy_n, 7);
        check("post_offset", int'(xo[0]), 0);

        rst[0] = 1'b1;
        tick[0] = 1'b1;
        @(negedge clock);
        rst[0] = 1'b0;
        tick[0] = 1'b0;
        m_off[0] = 0;
        m_cnt[0] = 0;
        check("rst_tick_busy0", int'(busy_o[0]), 0);
        @(negedge clock);
        check("rst_tick_busy1", int'(busy_o[0]), 0);

        do_reset(1);
        check("b_reset_offset", int'(xo[1]), 0);
        for (int i = 0; i < 1979; i++) frame(1, 1'b0, 1'b1, en_n, busy_n);
        check("b_preload", int'(xo[1]), 1979);
        for (int i = 0; i < 3; i++) begin
            frame(1, 1'b0, 1'b1, en_n, busy_n);
            check("b_saturate", int'(xo[1]), 1980);
        end

        repeat (3) @(negedge clock);
        check("final_queue", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
